nn_weight_loader: RTL and testbench

NN_WEIGHT_LOADER -- requirements
Module: nn_weight_loader

---
 rtl/nn_weight_loader_pkg.sv | 21 ++
 rtl/nn_weight_loader.sv | 112 +++++++++++
 tb/tb_nn_weight_loader.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/nn_weight_loader_pkg.sv
// Shared network dimensions, loader state encodings and the weight-count helper
// for the double-buffered genome weight loader.
package nn_weight_loader_pkg;

    localparam int NN_DATA_WIDTH  = 16;
    localparam int NN_INPUT_SIZE  = 2;
    localparam int NN_HIDDEN_SIZE = 2;
    localparam int NN_OUTPUT_SIZE = 1;

    typedef enum logic [1:0] {
        NN_LOADER_FILL  = 2'd0,
        NN_LOADER_DRAIN = 2'd1,
        NN_LOADER_FULL  = 2'd2
    } loader_state_t;

    // Hidden weights + hidden thresholds, then output weights + output thresholds.
    function automatic int nn_get_weights_size(input int n_in, input int n_hid, input int n_out);
        return n_in * n_hid + n_hid + n_hid * n_out + n_out;
    endfunction

endpackage

// File: rtl/nn_weight_loader.sv
// Streams a genome frame into a shadow buffer, checks its length, and publishes
// it to the active weight vector on swap.
module nn_weight_loader
    import nn_weight_loader_pkg::*;
#(
    parameter int data_width  = NN_DATA_WIDTH,
    parameter int input_size  = NN_INPUT_SIZE,
    parameter int hidden_size = NN_HIDDEN_SIZE,
    parameter int output_size = NN_OUTPUT_SIZE,
    localparam int W = nn_get_weights_size(input_size, hidden_size, output_size)
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [data_width-1:0]   in_word,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    input  logic                    swap,
    input  logic                    abort,
    output logic [data_width*W-1:0] weights,
    output logic                    weights_valid,
    output logic                    shadow_full,
    output logic                    frame_error
);

    typedef logic [$clog2(W)-1:0] count_t;

    loader_state_t          r_state, w_state_nxt;
    count_t                 r_count, w_count_nxt;
    logic [data_width*W-1:0] r_shadow;
    logic                   w_xfer;
    logic                   w_wr_en;
    logic                   w_publish;
    logic                   w_err_set;
    logic                   w_at_last;

    assign in_ready    = resetn && (r_state != NN_LOADER_FULL);
    assign shadow_full = (r_state == NN_LOADER_FULL);
    assign w_xfer      = in_valid && in_ready;
    assign w_at_last   = (r_count == count_t'(W - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_wr_en     = 1'b0;
        w_publish   = 1'b0;
        w_err_set   = 1'b0;
        if (abort) begin
            // Abort wins over any transfer or swap in the same cycle.
            w_state_nxt = NN_LOADER_FILL;
            w_count_nxt = '0;
        end else begin
            case (r_state)
                NN_LOADER_FILL: begin
                    if (w_xfer) begin
                        w_wr_en = 1'b1;
                        if (in_last) begin
                            w_count_nxt = '0;
                            if (w_at_last) w_state_nxt = NN_LOADER_FULL;
                            else           w_err_set   = 1'b1;
                        end else if (w_at_last) begin
                            w_err_set   = 1'b1;
                            w_count_nxt = '0;
                            w_state_nxt = NN_LOADER_DRAIN;
                        end else begin
                            w_count_nxt = count_t'(r_count + 1);
                        end
                    end
                end
                NN_LOADER_DRAIN: begin
                    if (w_xfer && in_last) begin
                        w_state_nxt = NN_LOADER_FILL;
                        w_count_nxt = '0;
                    end
                end
                NN_LOADER_FULL: begin
                    if (swap) begin
                        w_publish   = 1'b1;
                        w_state_nxt = NN_LOADER_FILL;
                    end
                end
                default: begin
                    w_state_nxt = NN_LOADER_FILL;
                    w_count_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state       <= NN_LOADER_FILL;
            r_count       <= '0;
            r_shadow      <= '0;
            weights       <= '0;
            weights_valid <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            if (w_wr_en)
                r_shadow[r_count*data_width +: data_width] <= in_word;
            if (w_publish) begin
                weights       <= r_shadow;
                weights_valid <= 1'b1;
            end
            if (w_err_set)
                frame_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_nn_weight_loader.sv
// Directed bench for nn_weight_loader with a 2-2-1 network (9 words of 16 bits).
module tb_nn_weight_loader;

    localparam int DW = 16;
    localparam int NW = 9;
    localparam int VW = DW * NW;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic [DW-1:0] in_word = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic          swap = 1'b0;
    logic          abort = 1'b0;
    logic [VW-1:0] weights;
    logic          weights_valid;
    logic          shadow_full;
    logic          frame_error;

    int n_pass  = 0;
    int n_total = 0;

    nn_weight_loader #(
        .data_width (DW),
        .input_size (2),
        .hidden_size(2),
        .output_size(1)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .in_word      (in_word),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .swap         (swap),
        .abort        (abort),
        .weights      (weights),
        .weights_valid(weights_valid),
        .shadow_full  (shadow_full),
        .frame_error  (frame_error)
    );

    always #5 clock = ~clock;

    function automatic logic [VW-1:0] frame_vec(input int base);
        logic [VW-1:0] v;
        v = '0;
        for (int k = 0; k < NW; k++) v[k*DW +: DW] = DW'(base + k);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic send_word(input int d, input logic last, input logic ab, input logic sw);
        @(negedge clock);
        in_valid = 1'b1;
        in_word  = DW'(d);
        in_last  = last;
        abort    = ab;
        swap     = sw;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        abort    = 1'b0;
        swap     = 1'b0;
    endtask

    task automatic send_frame(input int base, input int len);
        for (int i = 0; i < len; i++) send_word(base + i, (i == len - 1), 1'b0, 1'b0);
    endtask

    task automatic pulse_swap();
        @(negedge clock);
        swap = 1'b1;
        @(posedge clock);
        #1;
        swap = 1'b0;
    endtask

    task automatic pulse_abort();
        @(negedge clock);
        abort = 1'b1;
        @(posedge clock);
        #1;
        abort = 1'b0;
    endtask

    initial begin
        // Power-on reset
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_in_ready", VW'(in_ready), VW'(0));
        chk("rst_weights", weights, '0);
        chk("rst_wvalid", VW'(weights_valid), VW'(0));
        chk("rst_ferr", VW'(frame_error), VW'(0));
        chk("rst_sfull", VW'(shadow_full), VW'(0));
        resetn = 1'b1;
        @(negedge clock);
        chk("post_rst_ready", VW'(in_ready), VW'(1));

        // Nominal frame 1..9 then swap
        send_frame(1, NW);
        @(negedge clock);
        chk("f1_sfull", VW'(shadow_full), VW'(1));
        chk("f1_ready_low", VW'(in_ready), VW'(0));
        chk("f1_weights_pre", weights, '0);
        chk("f1_wvalid_pre", VW'(weights_valid), VW'(0));
        pulse_swap();
        @(negedge clock);
        chk("f1_weights", weights, frame_vec(1));
        chk("f1_wvalid", VW'(weights_valid), VW'(1));
        chk("f1_sfull_clr", VW'(shadow_full), VW'(0));
        chk("f1_ready_back", VW'(in_ready), VW'(1));

        // Backpressure while FULL
        send_frame(11, NW);
        @(negedge clock);
        in_valid = 1'b1;
        in_word  = 16'hDEAD;
        repeat (5) @(posedge clock);
        @(negedge clock);
        chk("bp_ready", VW'(in_ready), VW'(0));
        chk("bp_sfull", VW'(shadow_full), VW'(1));
        chk("bp_weights_hold", weights, frame_vec(1));
        in_valid = 1'b0;
        pulse_swap();
        @(negedge clock);
        chk("bp_weights", weights, frame_vec(11));
        pulse_swap();
        @(negedge clock);
        chk("swap_in_fill", weights, frame_vec(11));
        chk("swap_in_fill_valid", VW'(weights_valid), VW'(1));

        // Short frame of 5 words
        send_frame(100, 5);
        @(negedge clock);
        chk("short_ferr", VW'(frame_error), VW'(1));
        chk("short_sfull", VW'(shadow_full), VW'(0));
        chk("short_ready", VW'(in_ready), VW'(1));
        chk("short_weights", weights, frame_vec(11));
        send_frame(21, NW);
        @(negedge clock);
        chk("short_next_sfull", VW'(shadow_full), VW'(1));
        pulse_swap();
        @(negedge clock);
        chk("short_next_weights", weights, frame_vec(21));

        // Reset in the middle of a frame, at word 6
        send_frame(31, 5);
        @(negedge clock);
        resetn   = 1'b0;
        in_valid = 1'b1;
        in_word  = 16'd36;
        #1;
        chk("midrst_ready", VW'(in_ready), VW'(0));
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        @(negedge clock);
        chk("midrst_weights", weights, '0);
        chk("midrst_wvalid", VW'(weights_valid), VW'(0));
        chk("midrst_ferr", VW'(frame_error), VW'(0));
        chk("midrst_sfull", VW'(shadow_full), VW'(0));
        resetn = 1'b1;
        @(negedge clock);
        chk("midrst_ready_after", VW'(in_ready), VW'(1));

        // Long frame of 12 words
        for (int i = 0; i < NW; i++) send_word(41 + i, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        chk("long_ferr", VW'(frame_error), VW'(1));
        chk("long_drain_sfull", VW'(shadow_full), VW'(0));
        chk("long_drain_ready", VW'(in_ready), VW'(1));
        send_word(50, 1'b0, 1'b0, 1'b0);
        send_word(51, 1'b0, 1'b0, 1'b0);
        send_word(52, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        chk("long_end_sfull", VW'(shadow_full), VW'(0));
        chk("long_weights", weights, '0);
        chk("long_wvalid", VW'(weights_valid), VW'(0));
        send_frame(61, NW);
        @(negedge clock);
        chk("long_next_sfull", VW'(shadow_full), VW'(1));
        pulse_swap();
        @(negedge clock);
        chk("long_next_weights", weights, frame_vec(61));
        chk("long_next_wvalid", VW'(weights_valid), VW'(1));

        // Abort at word 4 together with swap
        send_frame(71, 3);
        send_word(74, 1'b0, 1'b1, 1'b1);
        @(negedge clock);
        chk("abort_weights", weights, frame_vec(61));
        chk("abort_sfull", VW'(shadow_full), VW'(0));
        chk("abort_ferr_sticky", VW'(frame_error), VW'(1));
        send_frame(81, NW);
        @(negedge clock);
        chk("abort_next_sfull", VW'(shadow_full), VW'(1));
        pulse_swap();
        @(negedge clock);
        chk("abort_next_weights", weights, frame_vec(81));

        // Abort while FULL drops the pending frame
        send_frame(91, NW);
        @(negedge clock);
        chk("full_abort_pre", VW'(shadow_full), VW'(1));
        pulse_abort();
        @(negedge clock);
        chk("full_abort_sfull", VW'(shadow_full), VW'(0));
        pulse_swap();
        @(negedge clock);
        chk("full_abort_weights", weights, frame_vec(81));
        chk("full_abort_wvalid", VW'(weights_valid), VW'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
